// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_ctrl_pkg : opcodes, FSM encoding and response record shared by the
//                ALU request scheduler.
// Revision     : 1.0
//------------------------------------------------------------------------------
package alu_ctrl_pkg;

   localparam int DATA_W = 4;
   localparam int MUL_W  = 8;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_MOD  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_ROR  = 4'b0111;
   localparam logic [3:0] OP_ROL  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_AND  = 4'b1010;
   localparam logic [3:0] OP_XOR  = 4'b1011;
   localparam logic [3:0] OP_NOT  = 4'b1100;
   localparam logic [3:0] OP_NOR  = 4'b1101;
   localparam logic [3:0] OP_XNOR = 4'b1110;
   localparam logic [3:0] OP_NAND = 4'b1111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic              id;
      logic [DATA_W-1:0] c;
      logic              carry;
      logic [MUL_W-1:0]  mul;
      logic              err;
   } rsp_t;

   function automatic logic is_div_zero(input logic [DATA_W-1:0] sel,
                                        input logic [DATA_W-1:0] b);
      return ((sel == OP_DIV) || (sel == OP_MOD)) && (b == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_req_scheduler_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_req_scheduler_if : two request channels, the shared-ALU port and the
//                        response channel of the scheduler.
// Revision             : 1.0
//------------------------------------------------------------------------------
interface alu_req_scheduler_if;
   import alu_ctrl_pkg::*;

   logic              req0_valid;
   logic              req0_ready;
   logic [DATA_W-1:0] req0_sel;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;

   logic              req1_valid;
   logic              req1_ready;
   logic [DATA_W-1:0] req1_sel;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_sel;
   logic [DATA_W-1:0] alu_c;
   logic              alu_carry;
   logic [MUL_W-1:0]  alu_mul;

   logic              rsp_valid;
   logic              rsp_ready;
   logic              rsp_id;
   logic [DATA_W-1:0] rsp_c;
   logic              rsp_carry;
   logic [MUL_W-1:0]  rsp_mul;
   logic              rsp_err;

   // Requesters, ALU and response consumer
   modport master (
      output req0_valid, req0_sel, req0_a, req0_b,
      output req1_valid, req1_sel, req1_a, req1_b,
      input  req0_ready, req1_ready,
      input  alu_a, alu_b, alu_sel,
      output alu_c, alu_carry, alu_mul,
      input  rsp_valid, rsp_id, rsp_c, rsp_carry, rsp_mul, rsp_err,
      output rsp_ready
   );

   // Scheduler
   modport slave (
      input  req0_valid, req0_sel, req0_a, req0_b,
      input  req1_valid, req1_sel, req1_a, req1_b,
      output req0_ready, req1_ready,
      output alu_a, alu_b, alu_sel,
      input  alu_c, alu_carry, alu_mul,
      output rsp_valid, rsp_id, rsp_c, rsp_carry, rsp_mul, rsp_err,
      input  rsp_ready
   );

endinterface
`default_nettype wire

// File: rtl/alu_rr_arb2.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_rr_arb2 : two-way round-robin arbiter with an internal favour pointer.
// Revision    : 1.0
//------------------------------------------------------------------------------
module alu_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic r_ptr;

   always_comb begin
      grant = 2'b00;
      if (!r_ptr) begin
         if (valid[0])      grant = 2'b01;
         else if (valid[1]) grant = 2'b10;
      end else begin
         if (valid[1])      grant = 2'b10;
         else if (valid[0]) grant = 2'b01;
      end
   end

   // After a grant the other requester becomes the favoured one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         r_ptr <= grant[0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_req_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_req_scheduler : shares one combinational ALU between two requesters and
//                     returns tagged results on a valid/ready channel.
// Revision          : 1.0
//------------------------------------------------------------------------------
module alu_req_scheduler
   import alu_ctrl_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   alu_req_scheduler_if.slave  bus
);

   localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(SETTLE_CYCLES - 1);

   logic [1:0]        r_state;
   logic [DATA_W-1:0] r_sel;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_id;
   logic [c_cnt_w-1:0] r_cnt;
   rsp_t              r_rsp;

   logic [1:0]        w_grant;
   logic              w_accept;
   rsp_t              w_capture;

   alu_rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   ({bus.req1_valid, bus.req0_valid}),
      .advance (w_accept),
      .grant   (w_grant)
   );

   always_comb begin
      bus.req0_ready = (r_state == ST_IDLE) && w_grant[0];
      bus.req1_ready = (r_state == ST_IDLE) && w_grant[1];
      w_accept       = (r_state == ST_IDLE) && (w_grant != 2'b00);
   end

   // Carry and product are gated by opcode: the ALU leaves them stale otherwise
   always_comb begin
      w_capture.id    = r_id;
      w_capture.err   = is_div_zero(r_sel, r_b);
      w_capture.c     = w_capture.err ? '0 : bus.alu_c;
      w_capture.carry = (r_sel == OP_ADD) ? bus.alu_carry : 1'b0;
      w_capture.mul   = (r_sel == OP_MUL) ? bus.alu_mul : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_id    <= 1'b0;
         r_cnt   <= '0;
         r_rsp   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_sel   <= w_grant[1] ? bus.req1_sel : bus.req0_sel;
                  r_a     <= w_grant[1] ? bus.req1_a   : bus.req0_a;
                  r_b     <= w_grant[1] ? bus.req1_b   : bus.req0_b;
                  r_id    <= w_grant[1];
                  r_cnt   <= c_cnt_load;
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (r_cnt == '0) begin
                  r_rsp   <= w_capture;
                  r_state <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - c_cnt_w'(1);
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Operand registers also drive the ALU in IDLE so its inputs do not toggle
   assign bus.alu_a     = r_a;
   assign bus.alu_b     = r_b;
   assign bus.alu_sel   = r_sel;

   assign bus.rsp_valid = (r_state == ST_RESP);
   assign bus.rsp_id    = r_rsp.id;
   assign bus.rsp_c     = r_rsp.c;
   assign bus.rsp_carry = r_rsp.carry;
   assign bus.rsp_mul   = r_rsp.mul;
   assign bus.rsp_err   = r_rsp.err;

endmodule
`default_nettype wire

// File: tb/tb_alu_req_scheduler.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_alu_req_scheduler : directed bench for the scheduler with a behavioural
//                        ALU that presents stale carry/product on other ops.
// Revision             : 1.0
//------------------------------------------------------------------------------
module tb_alu_req_scheduler;
   import alu_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst1_n;
   logic rst4_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   alu_req_scheduler_if bus1();
   alu_req_scheduler_if bus4();

   alu_req_scheduler #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));
   alu_req_scheduler #(.SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .rst_n(rst4_n), .bus(bus4));

   always #5 clk = ~clk;

   // Returns {carry, c, mul}; non-add carry is 1 and non-mul product is {a,b}
   function automatic logic [12:0] alu_model(input logic [3:0] sel,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
      logic [4:0] s;
      logic [7:0] p;
      logic [3:0] c;
      logic       cy;
      logic [7:0] m;
      s  = {1'b0, a} + {1'b0, b};
      p  = {4'd0, a} * {4'd0, b};
      cy = 1'b1;
      m  = {a, b};
      case (sel)
         OP_ADD:  begin c = s[3:0]; cy = s[4]; end
         OP_SUB:  c = a - b;
         OP_MUL:  begin c = p[3:0]; m = p; end
         OP_DIV:  c = (b == 4'd0) ? 4'hF : a / b;
         OP_MOD:  c = (b == 4'd0) ? 4'hF : a % b;
         OP_SHL:  c = a << 1;
         OP_OR:   c = a | b;
         OP_AND:  c = a & b;
         OP_XOR:  c = a ^ b;
         default: c = ~(a & b);
      endcase
      return {cy, c, m};
   endfunction

   assign {bus1.alu_carry, bus1.alu_c, bus1.alu_mul} = alu_model(bus1.alu_sel, bus1.alu_a, bus1.alu_b);
   assign {bus4.alu_carry, bus4.alu_c, bus4.alu_mul} = alu_model(bus4.alu_sel, bus4.alu_a, bus4.alu_b);

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Issue one op on the SETTLE_CYCLES=1 instance; returns cycles from accept to rsp_valid
   task automatic do_op1(input logic id, input logic [3:0] sel, input logic [3:0] a,
                         input logic [3:0] b, output int lat);
      int w;
      if (!id) begin
         bus1.req0_valid = 1'b1; bus1.req0_sel = sel; bus1.req0_a = a; bus1.req0_b = b;
      end else begin
         bus1.req1_valid = 1'b1; bus1.req1_sel = sel; bus1.req1_a = a; bus1.req1_b = b;
      end
      #1;
      w = 0;
      while (!(id ? bus1.req1_ready : bus1.req0_ready) && w < 10) begin
         step();
         w++;
      end
      step();
      bus1.req0_valid = 1'b0;
      bus1.req1_valid = 1'b0;
      lat = 1;
      while (!bus1.rsp_valid && lat < 20) begin
         step();
         lat++;
      end
      if (w >= 10) lat = -1;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({bus1.rsp_valid, bus1.rsp_err, bus1.rsp_id, bus1.rsp_carry, bus1.rsp_c, bus1.rsp_mul} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_rsp: got %h, expected 0",
                  {bus1.rsp_valid, bus1.rsp_err, bus1.rsp_id, bus1.rsp_carry, bus1.rsp_c, bus1.rsp_mul});
      end
      n_checks++;
      if ({bus1.alu_a, bus1.alu_b, bus1.alu_sel, bus1.req0_ready, bus1.req1_ready} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_alu_ready: got %h, expected 0",
                  {bus1.alu_a, bus1.alu_b, bus1.alu_sel, bus1.req0_ready, bus1.req1_ready});
      end
   endtask

   task automatic test_add();
      int lat;
      do_op1(1'b0, OP_ADD, 4'd9, 4'd8, lat);
      n_checks++;
      if (lat !== 2) begin n_fail++; $display("FAIL add_latency: got %0d, expected 2", lat); end
      n_checks++;
      if ({bus1.rsp_id, bus1.rsp_c, bus1.rsp_carry, bus1.rsp_mul, bus1.rsp_err} !== {1'b0, 4'd1, 1'b1, 8'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL add_rsp: got id=%0d c=%0d carry=%0d mul=%0d err=%0d, expected 0/1/1/0/0",
                  bus1.rsp_id, bus1.rsp_c, bus1.rsp_carry, bus1.rsp_mul, bus1.rsp_err);
      end
      step();
      n_checks++;
      if (bus1.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL add_rsp_drop: got %b, expected 0", bus1.rsp_valid); end
   endtask

   task automatic test_div_zero();
      int lat;
      do_op1(1'b0, OP_DIV, 4'd7, 4'd0, lat);
      n_checks++;
      if ({bus1.rsp_err, bus1.rsp_c} !== {1'b1, 4'd0}) begin
         n_fail++;
         $display("FAIL div_zero: got err=%0d c=%0d, expected err=1 c=0", bus1.rsp_err, bus1.rsp_c);
      end
      step();
      do_op1(1'b0, OP_MOD, 4'd7, 4'd3, lat);
      n_checks++;
      if ({bus1.rsp_err, bus1.rsp_c} !== {1'b0, 4'd1}) begin
         n_fail++;
         $display("FAIL mod_ok: got err=%0d c=%0d, expected err=0 c=1", bus1.rsp_err, bus1.rsp_c);
      end
      step();
   endtask

   task automatic test_mul();
      int lat;
      do_op1(1'b1, OP_MUL, 4'd15, 4'd15, lat);
      n_checks++;
      if ({bus1.rsp_id, bus1.rsp_mul, bus1.rsp_carry} !== {1'b1, 8'hE1, 1'b0}) begin
         n_fail++;
         $display("FAIL mul_rsp: got id=%0d mul=%h carry=%0d, expected 1/e1/0",
                  bus1.rsp_id, bus1.rsp_mul, bus1.rsp_carry);
      end
      step();
      do_op1(1'b1, OP_AND, 4'd12, 4'd10, lat);
      n_checks++;
      if ({bus1.rsp_c, bus1.rsp_mul, bus1.rsp_carry} !== {4'd8, 8'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL and_no_stale: got c=%0d mul=%h carry=%0d, expected 8/00/0",
                  bus1.rsp_c, bus1.rsp_mul, bus1.rsp_carry);
      end
      step();
   endtask

   task automatic test_contention();
      int ng = 0, nr = 0, r0cnt = 0, r1cnt = 0, bad = 0, cyc = 0;
      logic [3:0] gord = '0;
      logic [3:0] rord = '0;
      bus1.req0_valid = 1'b1; bus1.req0_sel = OP_ADD; bus1.req0_a = 4'd1; bus1.req0_b = 4'd1;
      bus1.req1_valid = 1'b1; bus1.req1_sel = OP_XOR; bus1.req1_a = 4'd6; bus1.req1_b = 4'd3;
      #1;
      while (nr < 4 && cyc < 60) begin
         if (bus1.req0_ready && bus1.req1_ready) bad++;
         if (bus1.req0_ready) begin if (ng < 4) gord[ng] = 1'b0; ng++; r0cnt++; end
         if (bus1.req1_ready) begin if (ng < 4) gord[ng] = 1'b1; ng++; r1cnt++; end
         if (bus1.rsp_valid) begin
            if (bus1.rsp_c !== (bus1.rsp_id ? 4'd5 : 4'd2)) bad++;
            rord[nr] = bus1.rsp_id;
            nr++;
         end
         step();
         cyc++;
         if (ng >= 4) begin bus1.req0_valid = 1'b0; bus1.req1_valid = 1'b0; end
      end
      n_checks++;
      if (gord !== 4'b1010 || ng !== 4) begin
         n_fail++; $display("FAIL rr_grants: got order=%b count=%0d, expected 1010 count=4", gord, ng);
      end
      n_checks++;
      if (rord !== 4'b1010 || nr !== 4) begin
         n_fail++; $display("FAIL rr_rsp_ids: got order=%b count=%0d, expected 1010 count=4", rord, nr);
      end
      n_checks++;
      if (r0cnt !== 2 || r1cnt !== 2 || bad !== 0) begin
         n_fail++; $display("FAIL rr_ready_pulses: got r0=%0d r1=%0d bad=%0d, expected 2/2/0", r0cnt, r1cnt, bad);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus1.rsp_ready = 1'b0;
      do_op1(1'b0, OP_ADD, 4'd3, 4'd4, lat);
      bus1.req0_valid = 1'b1; bus1.req0_sel = OP_OR; bus1.req0_a = 4'd1; bus1.req0_b = 4'd2;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({bus1.rsp_valid, bus1.rsp_c, bus1.rsp_id, bus1.req0_ready} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got valid=%0d c=%0d id=%0d ready=%0d, expected 1/7/0/0",
                     i, bus1.rsp_valid, bus1.rsp_c, bus1.rsp_id, bus1.req0_ready);
         end
         step();
      end
      bus1.rsp_ready = 1'b1;
      #1;
      step();
      n_checks++;
      if ({bus1.rsp_valid, bus1.req0_ready} !== 2'b01) begin
         n_fail++; $display("FAIL bp_release: got valid=%0d ready=%0d, expected 0/1", bus1.rsp_valid, bus1.req0_ready);
      end
      step();
      bus1.req0_valid = 1'b0;
      n_checks++;
      if (bus1.rsp_c !== 4'd7) begin n_fail++; $display("FAIL bp_retain: got c=%0d, expected 7", bus1.rsp_c); end
      step();
      n_checks++;
      if ({bus1.rsp_valid, bus1.rsp_c} !== {1'b1, 4'd3}) begin
         n_fail++; $display("FAIL bp_next_op: got valid=%0d c=%0d, expected 1/3", bus1.rsp_valid, bus1.rsp_c);
      end
      step();
   endtask

   task automatic test_reset_mid_op();
      int lat, w, seen;
      bus4.req0_valid = 1'b1; bus4.req0_sel = OP_ADD; bus4.req0_a = 4'd2; bus4.req0_b = 4'd3;
      #1;
      n_checks++;
      if (bus4.req0_ready !== 1'b1) begin n_fail++; $display("FAIL s4_accept: got %b, expected 1", bus4.req0_ready); end
      step();
      bus4.req0_valid = 1'b0;
      n_checks++;
      if ({bus4.alu_a, bus4.alu_b} !== {4'd2, 4'd3}) begin
         n_fail++; $display("FAIL s4_operands: got a=%0d b=%0d, expected 2/3", bus4.alu_a, bus4.alu_b);
      end
      step();
      rst4_n = 1'b0;
      #1;
      n_checks++;
      if ({bus4.rsp_valid, bus4.alu_a, bus4.alu_b, bus4.alu_sel, bus4.rsp_c, bus4.rsp_err} !== 18'd0) begin
         n_fail++;
         $display("FAIL s4_async_reset: got %h, expected 0",
                  {bus4.rsp_valid, bus4.alu_a, bus4.alu_b, bus4.alu_sel, bus4.rsp_c, bus4.rsp_err});
      end
      step();
      step();
      rst4_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus4.rsp_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL s4_no_rsp: got %0d valid cycles, expected 0", seen); end
      bus4.req0_valid = 1'b1; bus4.req0_sel = OP_SHL; bus4.req0_a = 4'd5; bus4.req0_b = 4'd0;
      #1;
      w = 0;
      while (!bus4.req0_ready && w < 10) begin step(); w++; end
      step();
      bus4.req0_valid = 1'b0;
      lat = 1;
      while (!bus4.rsp_valid && lat < 20) begin step(); lat++; end
      n_checks++;
      if (lat !== 5 || w !== 0) begin
         n_fail++; $display("FAIL s4_latency: got %0d (wait %0d), expected 5 (wait 0)", lat, w);
      end
      n_checks++;
      if ({bus4.rsp_c, bus4.rsp_id, bus4.rsp_err} !== {4'd10, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL s4_shl: got c=%0d id=%0d err=%0d, expected 10/0/0", bus4.rsp_c, bus4.rsp_id, bus4.rsp_err);
      end
      step();
   endtask

   initial begin
      rst1_n = 1'b0;
      rst4_n = 1'b0;
      bus1.req0_valid = 1'b0; bus1.req0_sel = '0; bus1.req0_a = '0; bus1.req0_b = '0;
      bus1.req1_valid = 1'b0; bus1.req1_sel = '0; bus1.req1_a = '0; bus1.req1_b = '0;
      bus1.rsp_ready  = 1'b1;
      bus4.req0_valid = 1'b0; bus4.req0_sel = '0; bus4.req0_a = '0; bus4.req0_b = '0;
      bus4.req1_valid = 1'b0; bus4.req1_sel = '0; bus4.req1_a = '0; bus4.req1_b = '0;
      bus4.rsp_ready  = 1'b1;
      repeat (3) step();
      test_reset();
      rst1_n = 1'b1;
      rst4_n = 1'b1;
      step();
      test_add();
      test_div_zero();
      test_mul();
      test_contention();
      test_backpressure();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
